// File: rtl/instr_assembler_pkg.sv
// Shared instruction-format definitions for the fetch-to-decode path.
// Used by instr_assembler and Identify so both agree on how a prefix word is recognised.
package instr_pkg;

  // Primary opcode field position and the value that marks a prefix word.
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = 5;
  localparam logic [5:0]  PRIMARY_OPCODE_PREFIX = 6'b100000;

  // Assembler FSM states.
  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_PREFIX = 2'd1,
    S_OUT    = 2'd2
  } instr_state_e;

  // Instruction container: prefix in [31:0], suffix in [63:32].
  typedef logic [63:0] instr_t;

  function automatic logic is_prefix(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB] == PRIMARY_OPCODE_PREFIX;
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Handshake bundle between the fetch buffer, the instruction assembler and decode.
//   i_flush                          redirect: drop the held prefix and any pending output
//   i_word_valid/o_word_ready        fetch-side handshake
//   i_word, i_word_addr              fetched word and its byte address
//   o_instr_valid/i_instr_ready      decode-side handshake
//   o_instr, o_instr_addr            assembled instruction and address of its first word
//   o_is_prefixed, o_align_err       prefix flag and prefix-at-block-end flag
// slave: the assembler side. master: the surrounding fetch/decode logic.
interface instr_assembler_if #(
  parameter int unsigned ADDR_W = 64
);
  import instr_pkg::*;

  logic              i_flush;
  logic              i_word_valid;
  logic              o_word_ready;
  logic [31:0]       i_word;
  logic [ADDR_W-1:0] i_word_addr;
  logic              o_instr_valid;
  logic              i_instr_ready;
  instr_t            o_instr;
  logic [ADDR_W-1:0] o_instr_addr;
  logic              o_is_prefixed;
  logic              o_align_err;

  modport slave (
    input  i_flush, i_word_valid, i_word, i_word_addr, i_instr_ready,
    output o_word_ready, o_instr_valid, o_instr, o_instr_addr, o_is_prefixed, o_align_err
  );

  modport master (
    output i_flush, i_word_valid, i_word, i_word_addr, i_instr_ready,
    input  o_word_ready, o_instr_valid, o_instr, o_instr_addr, o_is_prefixed, o_align_err
  );

endinterface

// File: rtl/instr_assembler.sv
// Pairs prefix words with the following word into a 64-bit instruction container.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous reset, active-low
//   bus    instr_assembler_if.slave (fetch and decode handshakes, flush, flags)
// A prefix in the last word of a 64-byte block is emitted alone with o_align_err set,
// since its suffix lies beyond the block.
module instr_assembler
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input logic               i_clk,
  input logic               i_rst,
  instr_assembler_if.slave  bus
);

  instr_state_e      state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       pre_q, pre_d;
  logic [ADDR_W-1:0] pre_addr_q, pre_addr_d;
  logic              prefixed_q, prefixed_d;
  logic              align_err_q, align_err_d;
  logic              accept;
  logic              word_is_prefix;
  logic              at_block_end;

  // Ready may look through to i_instr_ready: a word can be taken in the same cycle the
  // held output is consumed, giving one instruction per cycle.
  assign bus.o_word_ready = i_rst && !bus.i_flush && (state_q != S_OUT || bus.i_instr_ready);
  assign accept           = bus.i_word_valid && bus.o_word_ready;
  assign word_is_prefix   = is_prefix(bus.i_word);
  assign at_block_end     = bus.i_word_addr[5:2] == 4'hF;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    pre_d       = pre_q;
    pre_addr_d  = pre_addr_q;
    prefixed_d  = prefixed_q;
    align_err_d = align_err_q;

    if (bus.i_flush) begin
      state_d     = S_EMPTY;
      prefixed_d  = 1'b0;
      align_err_d = 1'b0;
    end else begin
      unique case (state_q)
        S_EMPTY, S_OUT: begin
          if (state_q == S_OUT && bus.i_instr_ready) begin
            state_d = S_EMPTY;
          end
          if (accept) begin
            if (word_is_prefix && !at_block_end) begin
              pre_d      = bus.i_word;
              pre_addr_d = bus.i_word_addr;
              state_d    = S_PREFIX;
            end else begin
              // Plain word, or a stranded prefix flagged as an alignment error.
              instr_d     = {32'b0, bus.i_word};
              addr_d      = bus.i_word_addr;
              prefixed_d  = word_is_prefix;
              align_err_d = word_is_prefix;
              state_d     = S_OUT;
            end
          end
        end
        S_PREFIX: begin
          // The suffix is taken as-is: never re-checked for opcode or address.
          if (accept) begin
            instr_d     = {bus.i_word, pre_q};
            addr_d      = pre_addr_q;
            prefixed_d  = 1'b1;
            align_err_d = 1'b0;
            state_d     = S_OUT;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= S_EMPTY;
      instr_q     <= '0;
      addr_q      <= '0;
      pre_q       <= '0;
      pre_addr_q  <= '0;
      prefixed_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      pre_q       <= pre_d;
      pre_addr_q  <= pre_addr_d;
      prefixed_q  <= prefixed_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.o_instr_valid = state_q == S_OUT;
  assign bus.o_instr       = instr_q;
  assign bus.o_instr_addr  = addr_q;
  assign bus.o_is_prefixed = prefixed_q;
  assign bus.o_align_err   = align_err_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler with a queue of expected instructions.
module tb_instr_assembler;

  typedef struct packed {
    logic [63:0] instr;
    logic [63:0] addr;
    logic        pref;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  instr_assembler_if #(.ADDR_W(64)) bus ();

  instr_assembler #(.ADDR_W(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] i, input logic [63:0] a,
                              input logic p, input logic e);
    exp_t r;
    r.instr = i;
    r.addr  = a;
    r.pref  = p;
    r.err   = e;
    return r;
  endfunction

  // One clock: sample at negedge, score any output consumed on the coming edge.
  task automatic cycle(output logic acc);
    exp_t e;
    @(negedge clk);
    acc = bus.i_word_valid && bus.o_word_ready;
    if (rst && !bus.i_flush && bus.o_instr_valid && bus.i_instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("instr", bus.o_instr, e.instr);
        chk("instr_addr", bus.o_instr_addr, e.addr);
        chk("is_prefixed", 64'(bus.o_is_prefixed), 64'(e.pref));
        chk("align_err", 64'(bus.o_align_err), 64'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    logic a;
    cycle(a);
  endtask

  task automatic send(input logic [31:0] w, input logic [63:0] a, output int tries);
    logic acc;
    bus.i_word_valid = 1'b1;
    bus.i_word       = w;
    bus.i_word_addr  = a;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      cycle(acc);
      tries++;
    end
    chk("send_accept", 64'(acc), 64'd1);
    bus.i_word_valid = 1'b0;
  endtask

  initial begin
    int t;
    clk              = 1'b0;
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_word_valid = 1'b1;
    bus.i_word       = 32'h0000_0012;
    bus.i_word_addr  = 64'h0;
    bus.i_instr_ready = 1'b1;

    // Reset with a word offered.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.o_instr_valid), 64'd0);
    chk("rst_instr", bus.o_instr, 64'd0);
    chk("rst_addr", bus.o_instr_addr, 64'd0);
    chk("rst_pref", 64'(bus.o_is_prefixed), 64'd0);
    chk("rst_err", 64'(bus.o_align_err), 64'd0);
    chk("rst_word_ready", 64'(bus.o_word_ready), 64'd0);
    bus.i_word_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("release_word_ready", 64'(bus.o_word_ready), 64'd1);

    // Non-prefixed word.
    exp_q.push_back(mk(64'h0000_0000_0000_0012, 64'h1000, 1'b0, 1'b0));
    send(32'h0000_0012, 64'h1000, t);
    chk("latency_valid", 64'(bus.o_instr_valid), 64'd1);
    tick();

    // Prefixed pair.
    send(32'h0000_0020, 64'h1004, t);
    chk("prefix_no_out", 64'(bus.o_instr_valid), 64'd0);
    exp_q.push_back(mk(64'hDEAD_BEEF_0000_0020, 64'h1004, 1'b1, 1'b0));
    send(32'hDEAD_BEEF, 64'h1008, t);
    chk("pair_valid", 64'(bus.o_instr_valid), 64'd1);
    tick();

    // Legal pair ending at the block boundary, then a stranded prefix.
    send(32'h0000_0020, 64'h1038, t);
    exp_q.push_back(mk(64'h1234_5678_0000_0020, 64'h1038, 1'b1, 1'b0));
    send(32'h1234_5678, 64'h103C, t);
    exp_q.push_back(mk(64'h0000_0000_0000_0020, 64'h107C, 1'b1, 1'b1));
    send(32'h0000_0020, 64'h107C, t);
    chk("boundary_valid", 64'(bus.o_instr_valid), 64'd1);
    exp_q.push_back(mk(64'h0000_0000_0000_0012, 64'h1080, 1'b0, 1'b0));
    send(32'h0000_0012, 64'h1080, t);
    tick();

    // Backpressure: held output stays stable and fetch is stalled.
    bus.i_instr_ready = 1'b0;
    exp_q.push_back(mk(64'h0000_0000_0000_0011, 64'h2000, 1'b0, 1'b0));
    send(32'h0000_0011, 64'h2000, t);
    bus.i_word_valid = 1'b1;
    bus.i_word       = 32'h0000_0012;
    bus.i_word_addr  = 64'h2004;
    repeat (3) begin
      @(negedge clk);
      chk("bp_word_ready", 64'(bus.o_word_ready), 64'd0);
      chk("bp_valid", 64'(bus.o_instr_valid), 64'd1);
      chk("bp_instr", bus.o_instr, 64'h11);
      chk("bp_addr", bus.o_instr_addr, 64'h2000);
      @(posedge clk);
      #1;
    end
    bus.i_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(64'(32'h12 + i), 64'h2004 + 64'(4 * i), 1'b0, 1'b0));
      send(32'h12 + 32'(i), 64'h2004 + 64'(4 * i), t);
      chk("stream_tries", 64'(t), 64'd1);
      chk("stream_valid", 64'(bus.o_instr_valid), 64'd1);
    end
    tick();
    chk("stream_idle", 64'(bus.o_instr_valid), 64'd0);

    // Flush while a prefix is held: the flush-cycle word is refused.
    send(32'h0000_0020, 64'h3000, t);
    bus.i_flush      = 1'b1;
    bus.i_word_valid = 1'b1;
    bus.i_word       = 32'h0000_0099;
    bus.i_word_addr  = 64'h3004;
    @(negedge clk);
    chk("flush_word_ready", 64'(bus.o_word_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.i_flush      = 1'b0;
    bus.i_word_valid = 1'b0;
    chk("flush_no_out", 64'(bus.o_instr_valid), 64'd0);
    exp_q.push_back(mk(64'h0000_0000_0000_0012, 64'h3008, 1'b0, 1'b0));
    send(32'h0000_0012, 64'h3008, t);
    chk("after_flush_pref", 64'(bus.o_is_prefixed), 64'd0);
    tick();

    // Flush drops a pending output even with decode ready.
    send(32'h0000_0012, 64'h3100, t);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("flush_drop_out", 64'(bus.o_instr_valid), 64'd0);

    // Reset while a prefix is held.
    send(32'h0000_0020, 64'h4000, t);
    rst              = 1'b0;
    bus.i_word_valid = 1'b1;
    bus.i_word       = 32'h0000_0077;
    bus.i_word_addr  = 64'h4004;
    tick();
    chk("midrst_valid", 64'(bus.o_instr_valid), 64'd0);
    chk("midrst_instr", bus.o_instr, 64'd0);
    rst              = 1'b1;
    bus.i_word_valid = 1'b0;
    exp_q.push_back(mk(64'h0000_0000_0000_0012, 64'h4008, 1'b0, 1'b0));
    send(32'h0000_0012, 64'h4008, t);
    tick();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Assembles the 32-bit word stream from instruction fetch into the 64-bit instruction container consumed by `Identify`. The ISA bit numbering is kept, so ISA bit n is at index n. The prefix word goes in bits [31:0] and the suffix word in bits [63:32]. The block detects prefix words (primary opcode field [5:0] == 6'b100000) and pairs each prefix with the following word. It flags prefixes that sit in the last word of a 64-byte block and would cross the boundary. It sits between the fetch buffer and the decode stage, with valid/ready handshakes on both sides and a flush input for branch redirects.

## Interface
- `ADDR_W`, 64: width of instruction addresses.
- `i_clk`  in  1  clock, all logic on rising edge
- `i_rst`  in  1  synchronous reset, active-low
- `i_flush`  in  1  discard held prefix and pending output (redirect)
- `i_word_valid`  in  1  fetch word available
- `o_word_ready`  out  1  block accepts word this cycle
- `i_word`  in  32  fetched word, ISA bit n at index n
- `i_word_addr`  in  ADDR_W  byte address of `i_word`; bits [1:0] ignored
- `o_instr_valid`  out  1  assembled instruction available
- `i_instr_ready`  in  1  decode accepts instruction
- `o_instr`  out  64  non-prefixed: {32'b0, word}; prefixed: {suffix, prefix}
- `o_instr_addr`  out  ADDR_W  address of first word of instruction
- `o_is_prefixed`  out  1  `o_instr` holds a prefix
- `o_align_err`  out  1  prefix at address [5:2] == 4'hF; suffix not fetched

## Operation
- The state machine has three states: S_EMPTY, S_PREFIX and S_OUT.
- A word is accepted when `i_word_valid && o_word_ready`.
- `o_word_ready` = `i_rst && !i_flush && (state != S_OUT || i_instr_ready)`.
- S_EMPTY, accepting a word:
  - Non-prefix word: load `o_instr`={32'b0, word} and `o_instr_addr`, set prefixed=0, go to S_OUT.
  - Prefix with addr[5:2] != 4'hF: store prefix and address, go to S_PREFIX.
  - Prefix with addr[5:2] == 4'hF: load {32'b0, prefix}, set prefixed=1 and align_err=1, go to S_OUT.
- S_PREFIX, accepting a word: load {word, held prefix}, set prefixed=1, use the held address, go to S_OUT.
  - The suffix is never re-examined for the prefix opcode.
  - The suffix address is not checked.
- S_OUT:
  - `o_instr_valid`=1.
  - On `i_instr_ready` with no word accepted: go to S_EMPTY.
  - On `i_instr_ready` with a word accepted in the same cycle: apply the S_EMPTY rules to that word. This gives one instruction per cycle sustained.
- Flush (i_rst=1, i_flush=1):
  - Next state is S_EMPTY and all flags clear.
  - The word on `i_word` in the flush cycle is not accepted.
  - A valid output pending in the flush cycle is dropped, even if `i_instr_ready`=1.
- Priority: reset > flush > normal operation.

## Timing
- Reset values:
  - `o_instr_valid`=0, `o_is_prefixed`=0, `o_align_err`=0.
  - `o_instr`=0, `o_instr_addr`=0.
  - State S_EMPTY.
  - `o_word_ready`=0 while `i_rst`=0, and 1 in the first cycle after release.
- Latency: one cycle from acceptance of the last word (non-prefixed word, or suffix) to `o_instr_valid`=1.
- A prefix alone produces no output.
- Handshake: while `o_instr_valid && !i_instr_ready`, all outputs stay stable and `o_word_ready`=0.
- `o_instr_valid` never depends combinationally on `i_instr_ready`.
- `o_word_ready` has a combinational path from `i_instr_ready` and `i_flush`. This path is accepted.
- Reset asserted mid-instruction (S_PREFIX or S_OUT) discards everything on the next edge.
- Flush and word valid in the same cycle: the word is dropped and fetch must re-present it.
- A prefix at 0x...3C is a boundary error. A prefix at 0x...38 with its suffix at 0x...3C is legal.

## Structure
- Shared package `instr_pkg`:
  - `PRIMARY_OPCODE_PREFIX` = 6'b100000.
  - `OPCODE_LSB`=0, `OPCODE_MSB`=5.
  - The `instr_state_e` enum (S_EMPTY, S_PREFIX, S_OUT).
  - A 64-bit `instr_t` typedef.
  - `Identify` is updated to import the same opcode constant.
- Single module, no sub-module. The prefix detect is one compare and does not justify a hierarchy level.

## Test plan
- Reset: hold i_rst=0 for 2 cycles with i_word_valid=1 -> all outputs 0 and `o_word_ready`=0; after release, `o_word_ready`=1.
- Non-prefixed: word 0x0000_0012 at 0x1000, i_instr_ready=1 -> next cycle `o_instr`=0x0000_0000_0000_0012, addr 0x1000, prefixed=0, align_err=0.
- Prefixed pair: 0x0000_0020 at 0x1004, then 0xDEAD_BEEF at 0x1008 -> no output after the first word; one cycle after the suffix, `o_instr`=0xDEAD_BEEF_0000_0020, addr 0x1004, prefixed=1.
- Boundary: prefix 0x0000_0020 at 0x103C -> `o_instr`=0x0000_0000_0000_0020, prefixed=1, align_err=1; the next word 0x0000_0012 is emitted as non-prefixed.
- Backpressure: i_instr_ready=0 for 3 cycles with output valid -> `o_word_ready`=0 and outputs unchanged; on release, 4 back-to-back non-prefixed words emit on 4 consecutive cycles.
- Flush/reset mid-op: prefix accepted, then i_flush=1 with a word valid -> that word is dropped; next word 0x0000_0012 is emitted alone with prefixed=0. Repeat with i_rst=0 in S_PREFIX -> same result.
